// File: rtl/sram_arb_2port_if.sv
// sram_arb_2port_if: one requester's val/rdy request channel plus its val/rdy response channel
interface sram_arb_2port_if #(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 256
);
  logic                             req_val;
  logic                             req_rdy;
  logic                             req_type;
  logic [$clog2(p_num_entries)-1:0] req_idx;
  logic [p_data_nbits/8-1:0]        req_wben;
  logic [p_data_nbits-1:0]          req_wdata;
  logic                             resp_val;
  logic                             resp_rdy;
  logic                             resp_type;
  logic [p_data_nbits-1:0]          resp_data;
  modport master (output req_val, req_type, req_idx, req_wben, req_wdata, resp_rdy,
                  input  req_rdy, resp_val, resp_type, resp_data);
  modport slave  (input  req_val, req_type, req_idx, req_wben, req_wdata, resp_rdy,
                  output req_rdy, resp_val, resp_type, resp_data);
endinterface

// File: rtl/sram_arb_2port.sv
// sram_arb_2port: two-requester arbiter/sequencer for one single-port SRAM with per-requester 2-entry response queues.
// Round-robin by default; define SRAM_ARB_FIXED_PRIO_EN to make requester 0 always win.
module sram_arb_2port #(
  parameter  int p_data_nbits  = 32,
  parameter  int p_num_entries = 256,
  localparam int c_addr_nbits  = $clog2(p_num_entries),
  localparam int c_data_nbytes = p_data_nbits/8
) (
  input  logic                     clk,
  input  logic                     reset,
  sram_arb_2port_if.slave          req0,
  sram_arb_2port_if.slave          req1,
  output logic                     port0_val,
  output logic                     port0_type,
  output logic [c_addr_nbits-1:0]  port0_idx,
  output logic [c_data_nbytes-1:0] port0_wben,
  output logic [p_data_nbits-1:0]  port0_wdata,
  input  logic [p_data_nbits-1:0]  port0_rdata
);
  logic [1:0]               w_val, w_type, w_rrdy, w_deq, w_enq, w_el, w_cand, w_grant;
  logic                     w_g0, w_gnt, w_win;
  logic [c_addr_nbits-1:0]  w_idx   [2];
  logic [c_data_nbytes-1:0] w_wben  [2];
  logic [p_data_nbits-1:0]  w_wdata [2];
  logic [1:0]               r_occ   [2];
  logic [1:0]               r_head;
  logic [1:0]               r_q_type [2];
  logic [p_data_nbits-1:0]  r_q_data [2][2];
  logic                     r_infl_val, r_infl_own, r_infl_type;
`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic                     r_prio;
`endif

  assign w_val      = {req1.req_val, req0.req_val};
  assign w_type     = {req1.req_type, req0.req_type};
  assign w_rrdy     = {req1.resp_rdy, req0.resp_rdy};
  assign w_idx[0]   = req0.req_idx;
  assign w_idx[1]   = req1.req_idx;
  assign w_wben[0]  = req0.req_wben;
  assign w_wben[1]  = req1.req_wben;
  assign w_wdata[0] = req0.req_wdata;
  assign w_wdata[1] = req1.req_wdata;

  assign req0.req_rdy   = w_grant[0];
  assign req1.req_rdy   = w_grant[1];
  assign req0.resp_val  = r_occ[0] != 2'd0;
  assign req1.resp_val  = r_occ[1] != 2'd0;
  assign req0.resp_type = (r_occ[0] != 2'd0) && r_q_type[0][r_head[0]];
  assign req1.resp_type = (r_occ[1] != 2'd0) && r_q_type[1][r_head[1]];
  assign req0.resp_data = (r_occ[0] != 2'd0) ? r_q_data[0][r_head[0]] : '0;
  assign req1.resp_data = (r_occ[1] != 2'd0) ? r_q_data[1][r_head[1]] : '0;

  // A requester is eligible only if its queue can absorb everything already issued for it.
  always_comb begin
    w_deq = '0;
    w_enq = '0;
    w_el  = '0;
    for (int n = 0; n < 2; n++) begin
      w_deq[n] = (r_occ[n] != 2'd0) && w_rrdy[n];
      w_enq[n] = r_infl_val && (r_infl_own == 1'(n));
      w_el[n]  = ({1'b0, r_occ[n]} + {2'b0, w_enq[n]} - {2'b0, w_deq[n]}) < 3'd2;
    end
    w_cand = w_val & w_el;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    w_g0 = w_cand[0];
`else
    w_g0 = w_cand[0] && (!w_cand[1] || !r_prio);
`endif
    w_grant = {w_cand[1] && !w_g0, w_g0};
  end

  assign w_gnt       = |w_grant;
  assign w_win       = w_grant[1];
  assign port0_val   = w_gnt;
  assign port0_type  = w_gnt && w_type[w_win];
  assign port0_idx   = w_gnt ? w_idx[w_win]   : '0;
  assign port0_wben  = w_gnt ? w_wben[w_win]  : '0;
  assign port0_wdata = w_gnt ? w_wdata[w_win] : '0;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) r_prio <= 1'b0;
    else if (w_gnt) r_prio <= ~w_win;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_infl_val  <= 1'b0;
      r_infl_own  <= 1'b0;
      r_infl_type <= 1'b0;
      r_head      <= '0;
      for (int n = 0; n < 2; n++) begin
        r_occ[n]    <= '0;
        r_q_type[n] <= '0;
        for (int k = 0; k < 2; k++) r_q_data[n][k] <= '0;
      end
    end else begin
      r_infl_val  <= w_gnt;
      r_infl_own  <= w_win;
      r_infl_type <= port0_type;
      for (int n = 0; n < 2; n++) begin
        if (w_enq[n]) begin
          r_q_data[n][r_head[n] ^ r_occ[n][0]] <= r_infl_type ? '0 : port0_rdata;
          r_q_type[n][r_head[n] ^ r_occ[n][0]] <= r_infl_type;
        end
        r_occ[n]  <= r_occ[n] + {1'b0, w_enq[n]} - {1'b0, w_deq[n]};
        r_head[n] <= r_head[n] ^ w_deq[n];
      end
    end
endmodule

// File: tb/tb_sram_arb_2port.sv
// tb_sram_arb_2port: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_sram_arb_2port;
`ifdef SRAM_ARB_FIXED_PRIO_EN
  localparam bit fixed = 1'b1;
`else
  localparam bit fixed = 1'b0;
`endif
  typedef struct {logic t; logic [31:0] d;} resp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_arb_2port_if #(.p_data_nbits(32), .p_num_entries(256)) r0 ();
  sram_arb_2port_if #(.p_data_nbits(32), .p_num_entries(256)) r1 ();
  logic        p_val, p_type;
  logic [7:0]  p_idx;
  logic [3:0]  p_wben;
  logic [31:0] p_wdata, p_rdata;

  sram_arb_2port #(.p_data_nbits(32), .p_num_entries(256)) dut (
    .clk(clk), .reset(reset), .req0(r0), .req1(r1),
    .port0_val(p_val), .port0_type(p_type), .port0_idx(p_idx),
    .port0_wben(p_wben), .port0_wdata(p_wdata), .port0_rdata(p_rdata));

  // SRAM stub with one-cycle read latency and a preload path
  logic [31:0] mem [256];
  logic [31:0] gm  [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;
  always @(posedge clk)
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (p_val) begin
      if (p_type) begin
        for (int b = 0; b < 4; b++) if (p_wben[b]) mem[p_idx][8*b +: 8] <= p_wdata[8*b +: 8];
      end else p_rdata <= mem[p_idx];
    end

  int checks = 0;
  int errors = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0.req_val = 0; r0.req_type = 0; r0.req_idx = 0; r0.req_wben = 0; r0.req_wdata = 0;
    r1.req_val = 0; r1.req_type = 0; r1.req_idx = 0; r1.req_wben = 0; r1.req_wdata = 0;
  endtask

  task automatic rq(input int n, input logic v, input logic t, input logic [7:0] i,
                    input logic [3:0] be, input logic [31:0] d);
    if (n == 0) begin
      r0.req_val = v; r0.req_type = t; r0.req_idx = i; r0.req_wben = be; r0.req_wdata = d;
    end else begin
      r1.req_val = v; r1.req_type = t; r1.req_idx = i; r1.req_wben = be; r1.req_wdata = d;
    end
  endtask

  task automatic gm_write(input logic [7:0] i, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (be[b]) gm[i][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b0 || r1.resp_val !== 1'b0) begin errors++; $display("FAIL reset_resp_val got %b%b exp 00", r1.resp_val, r0.resp_val); end
    checks++; if (r0.resp_data !== 32'h0 || r0.resp_type !== 1'b0) begin errors++; $display("FAIL reset_resp0_fields got %h/%b exp 0/0", r0.resp_data, r0.resp_type); end
    checks++; if (p_val !== 1'b0 || p_idx !== 8'h0 || p_wdata !== 32'h0 || p_wben !== 4'h0 || p_type !== 1'b0) begin errors++; $display("FAIL reset_port0 got val %b idx %h exp all zero", p_val, p_idx); end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (r0.req_rdy !== 1'b0 || r1.req_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy_noval got %b%b exp 00", r1.req_rdy, r0.req_rdy); end
    cyc();
  endtask

  task automatic test_single_read();
    rq(0, 1, 0, 8'd5, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (r0.req_rdy !== 1'b1 || p_val !== 1'b1 || p_idx !== 8'd5 || p_type !== 1'b0) begin errors++; $display("FAIL single_issue got rdy %b val %b idx %h exp 1 1 05", r0.req_rdy, p_val, p_idx); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", r0.resp_val); end
    cyc();
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b1 || r0.resp_data !== 32'hDEADBEEF || r0.resp_type !== 1'b0) begin errors++; $display("FAIL single_resp got %b %h %b exp 1 deadbeef 0", r0.resp_val, r0.resp_data, r0.resp_type); end
    cyc();
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b0) begin errors++; $display("FAIL single_consumed got %b exp 0", r0.resp_val); end
    cyc();
  endtask

  task automatic test_byte_write();
    rq(1, 1, 1, 8'd3, 4'b0101, 32'h11223344);
    gm_write(8'd3, 4'b0101, 32'h11223344);
    @(negedge clk);
    checks++; if (r1.req_rdy !== 1'b1 || p_type !== 1'b1 || p_wben !== 4'b0101 || p_wdata !== 32'h11223344) begin errors++; $display("FAIL bw_issue got rdy %b type %b wben %b exp 1 1 0101", r1.req_rdy, p_type, p_wben); end
    cyc(); idle(); cyc();
    rq(1, 1, 0, 8'd3, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (r1.resp_val !== 1'b1 || r1.resp_type !== 1'b1 || r1.resp_data !== 32'h0) begin errors++; $display("FAIL bw_resp got %b %b %h exp 1 1 0", r1.resp_val, r1.resp_type, r1.resp_data); end
    checks++; if (r1.req_rdy !== 1'b1) begin errors++; $display("FAIL bw_readback_issue got %b exp 1", r1.req_rdy); end
    cyc(); idle(); cyc();
    @(negedge clk);
    checks++; if (r1.resp_val !== 1'b1 || r1.resp_data !== 32'hAA22AA44 || r1.resp_type !== 1'b0) begin errors++; $display("FAIL bw_readback got %b %h exp 1 aa22aa44", r1.resp_val, r1.resp_data); end
    cyc();
  endtask

  task automatic test_conflict();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      logic e0;
      e0 = fixed ? 1'b1 : (c % 2 == 0);
      rq(0, 1, 0, 8'(c), 4'h0, 32'h0);
      rq(1, 1, 0, 8'(c + 100), 4'h0, 32'h0);
      @(negedge clk);
      checks++; if (r0.req_rdy !== e0 || r1.req_rdy !== !e0) begin errors++; $display("FAIL conflict_c%0d got %b%b exp %b%b", c, r1.req_rdy, r0.req_rdy, !e0, e0); end
      cyc();
    end
    idle(); cyc(); cyc(); cyc();
  endtask

  task automatic test_backpressure();
    int a0 = 0;
    r0.resp_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rq(0, 1, 0, 8'(10 + a0), 4'h0, 32'h0);
      rq(1, 1, 0, 8'(20 + c), 4'h0, 32'h0);
      @(negedge clk);
      if (c >= 3) begin
        checks++; if (r0.req_rdy !== 1'b0 || r1.req_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_c%0d got %b%b exp 10", c, r1.req_rdy, r0.req_rdy); end
      end
      if (r0.req_rdy === 1'b1) a0++;
      cyc();
    end
    checks++; if (a0 != 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", a0); end
    idle(); cyc(); cyc();
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b1 || r0.resp_data !== gm[10] || r1.resp_val !== 1'b0) begin errors++; $display("FAIL bp_hold got %b %h exp 1 %h", r0.resp_val, r0.resp_data, gm[10]); end
    cyc();
    r0.resp_rdy = 1'b1;
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b1 || r0.resp_data !== gm[10]) begin errors++; $display("FAIL bp_drain0 got %b %h exp 1 %h", r0.resp_val, r0.resp_data, gm[10]); end
    cyc();
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b1 || r0.resp_data !== gm[11]) begin errors++; $display("FAIL bp_drain1 got %b %h exp 1 %h", r0.resp_val, r0.resp_data, gm[11]); end
    cyc();
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", r0.resp_val); end
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      if (c < 8) rq(0, 1, 0, 8'(c), 4'h0, 32'h0); else idle();
      @(negedge clk);
      if (c < 8) begin
        checks++; if (r0.req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_c%0d got %b exp 1", c, r0.req_rdy); end
      end
      if (c >= 2) begin
        checks++; if (r0.resp_val !== 1'b1 || r0.resp_data !== gm[c-2]) begin errors++; $display("FAIL b2b_resp_c%0d got %b %h exp 1 %h", c, r0.resp_val, r0.resp_data, gm[c-2]); end
      end
      cyc();
    end
    idle(); cyc();
  endtask

  task automatic test_random();
    resp_t       mq [2][$];
    logic        iv = 1'b0;
    int          io = 0;
    int          prio = 0;
    resp_t       id;
    logic        tv [2], tt [2], tr [2];
    logic [7:0]  ti [2];
    logic [3:0]  tb [2];
    logic [31:0] td [2];
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic ev [2], dq [2], cd [2];
      int g;
      for (int n = 0; n < 2; n++) begin
        tv[n] = $urandom_range(0, 3) != 0;
        tt[n] = 1'($urandom_range(0, 1));
        ti[n] = 8'($urandom_range(0, 15));
        tb[n] = 4'($urandom);
        td[n] = $urandom;
        tr[n] = $urandom_range(0, 3) != 0;
        rq(n, tv[n], tt[n], ti[n], tb[n], td[n]);
        ev[n] = mq[n].size() != 0;
        dq[n] = ev[n] && tr[n];
        cd[n] = tv[n] && (mq[n].size() + ((iv && io == n) ? 1 : 0) - (dq[n] ? 1 : 0) < 2);
      end
      r0.resp_rdy = tr[0];
      r1.resp_rdy = tr[1];
      g = (cd[0] && cd[1]) ? (fixed ? 0 : prio) : cd[0] ? 0 : cd[1] ? 1 : -1;
      @(negedge clk);
      checks++; if (r0.req_rdy !== (g == 0) || r1.req_rdy !== (g == 1)) begin errors++; $display("FAIL rnd_grant k%0d got %b%b exp grant %0d", k, r1.req_rdy, r0.req_rdy, g); end
      checks++; if (r0.resp_val !== ev[0] || r1.resp_val !== ev[1]) begin errors++; $display("FAIL rnd_resp_val k%0d got %b%b exp %b%b", k, r1.resp_val, r0.resp_val, ev[1], ev[0]); end
      if (ev[0]) begin
        checks++; if (r0.resp_type !== mq[0][0].t || r0.resp_data !== mq[0][0].d) begin errors++; $display("FAIL rnd_resp0 k%0d got %b %h exp %b %h", k, r0.resp_type, r0.resp_data, mq[0][0].t, mq[0][0].d); end
      end
      if (ev[1]) begin
        checks++; if (r1.resp_type !== mq[1][0].t || r1.resp_data !== mq[1][0].d) begin errors++; $display("FAIL rnd_resp1 k%0d got %b %h exp %b %h", k, r1.resp_type, r1.resp_data, mq[1][0].t, mq[1][0].d); end
      end
      if (g >= 0) begin
        checks++; if (p_val !== 1'b1 || p_idx !== ti[g] || p_type !== tt[g] || (tt[g] && (p_wben !== tb[g] || p_wdata !== td[g]))) begin errors++; $display("FAIL rnd_port k%0d got %b %h %b exp 1 %h %b", k, p_val, p_idx, p_type, ti[g], tt[g]); end
      end else begin
        checks++; if (p_val !== 1'b0 || p_idx !== 8'h0 || p_wdata !== 32'h0) begin errors++; $display("FAIL rnd_port_idle k%0d got %b %h exp 0 00", k, p_val, p_idx); end
      end
      for (int n = 0; n < 2; n++) if (dq[n]) void'(mq[n].pop_front());
      if (iv) mq[io].push_back(id);
      iv = g >= 0;
      if (g >= 0) begin
        io = g;
        id.t = tt[g];
        id.d = tt[g] ? 32'h0 : gm[ti[g]];
        if (tt[g]) gm_write(ti[g], tb[g], td[g]);
        prio = 1 - g;
      end
      cyc();
    end
    idle();
    r0.resp_rdy = 1'b1;
    r1.resp_rdy = 1'b1;
  endtask

  task automatic test_reset_midop();
    int a0 = 0;
    do_reset();
    r0.resp_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rq(0, 1, 0, 8'(40 + a0), 4'h0, 32'h0);
      @(negedge clk);
      if (r0.req_rdy === 1'b1) a0++;
      cyc();
    end
    idle();
    rq(1, 1, 0, 8'd60, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (r1.req_rdy !== 1'b1 || r0.resp_val !== 1'b1 || a0 != 2) begin errors++; $display("FAIL rm_setup got rdy1 %b val0 %b acc %0d exp 1 1 2", r1.req_rdy, r0.resp_val, a0); end
    cyc();
    idle();
    reset = 1'b1;
    #1;
    checks++; if (r0.resp_val !== 1'b0 || r1.resp_val !== 1'b0 || p_val !== 1'b0) begin errors++; $display("FAIL rm_drop got %b %b %b exp 0 0 0", r0.resp_val, r1.resp_val, p_val); end
    cyc();
    reset = 1'b0;
    r0.resp_rdy = 1'b1;
    @(negedge clk);
    checks++; if (r1.resp_val !== 1'b0 || r0.resp_val !== 1'b0) begin errors++; $display("FAIL rm_no_resp got %b %b exp 0 0", r0.resp_val, r1.resp_val); end
    cyc();
    rq(0, 1, 0, 8'd50, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (r0.req_rdy !== 1'b1) begin errors++; $display("FAIL rm_new_issue got %b exp 1", r0.req_rdy); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b0 || r1.resp_val !== 1'b0) begin errors++; $display("FAIL rm_early got %b %b exp 0 0", r0.resp_val, r1.resp_val); end
    cyc();
    @(negedge clk);
    checks++; if (r0.resp_val !== 1'b1 || r0.resp_data !== gm[50]) begin errors++; $display("FAIL rm_new_resp got %b %h exp 1 %h", r0.resp_val, r0.resp_data, gm[50]); end
    cyc();
  endtask

  initial begin
    idle();
    r0.resp_rdy = 1'b1;
    r1.resp_rdy = 1'b1;
    pl_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pl_idx = 8'(i);
      pl_data = $urandom;
      gm[i] = pl_data;
      cyc();
    end
    pl_idx = 8'd5; pl_data = 32'hDEADBEEF; gm[5] = pl_data; cyc();
    pl_idx = 8'd3; pl_data = 32'hAAAAAAAA; gm[3] = pl_data; cyc();
    pl_en = 1'b0;
    test_reset();
    test_single_read();
    test_byte_write();
    test_conflict();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
